// File: rtl/aes_block_packer_pkcs7.sv
// rtl/aes_block_packer_pkcs7.sv - packs a word stream into 128-bit PKCS#7-padded blocks for AES-CBC
module aes_block_packer_pkcs7 #(
    parameter int WORD_W = 32,
    parameter int NB_W   = $clog2(WORD_W/8)+1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              msg_start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [NB_W-1:0]   in_nbytes,
    output logic              in_ready,
    output logic              cbc_start,
    output logic [127:0]      blk_data,
    output logic              blk_valid,
    output logic              blk_last,
    input  logic              blk_ready,
    output logic              busy,
    output logic [31:0]       msg_bytes
);
    localparam int WB = WORD_W/8;

    typedef enum logic [2:0] {S_IDLE, S_START, S_FILL, S_OUT, S_PADBLK} state_t;

    state_t       state, state_nxt;
    logic [4:0]   off_q;
    logic         pad_pending;
    logic [4:0]   nb_eff;
    logic [4:0]   n_nxt;
    logic [WORD_W-1:0] word_masked;
    logic [127:0] buf_wr;
    logic [127:0] buf_pad;
    logic [7:0]   pad_byte;
    logic [32:0]  sum;
    logic         xfer_in;
    logic         xfer_out;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = blk_valid & blk_ready;

    // Out-of-range byte counts on a last word fall back to a full word.
    always_comb begin
        nb_eff = 5'(WB);
        if (in_last && in_nbytes != '0 && int'(in_nbytes) <= WB)
            nb_eff = 5'(in_nbytes);
    end

    // Words land at byte offset off_q; bytes past off_q are still zero, so OR merges them.
    assign n_nxt       = off_q + nb_eff;
    assign word_masked = in_data & ~({WORD_W{1'b1}} >> (8*nb_eff));
    assign buf_wr      = blk_data | ({word_masked, {(128-WORD_W){1'b0}}} >> (8*off_q));
    assign pad_byte    = {3'b000, 5'd16 - n_nxt};
    assign buf_pad     = buf_wr | ({16{pad_byte}} & ({128{1'b1}} >> (8*n_nxt)));
    assign sum         = {1'b0, msg_bytes} + {28'd0, nb_eff};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (msg_start) state_nxt = S_START;
            S_START:  state_nxt = S_FILL;
            S_FILL:   if (xfer_in && (in_last || n_nxt == 5'd16)) state_nxt = S_OUT;
            S_OUT: begin
                if (blk_ready) begin
                    if (blk_last)         state_nxt = S_IDLE;
                    else if (pad_pending) state_nxt = S_PADBLK;
                    else                  state_nxt = S_FILL;
                end
            end
            S_PADBLK: if (blk_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        cbc_start = 1'b0;
        blk_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_START:  cbc_start = 1'b1;
            S_FILL:   in_ready  = 1'b1;
            S_OUT:    blk_valid = 1'b1;
            S_PADBLK: blk_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_data    <= '0;
            blk_last    <= 1'b0;
            off_q       <= '0;
            pad_pending <= 1'b0;
            msg_bytes   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (msg_start) begin
                        blk_data    <= '0;
                        blk_last    <= 1'b0;
                        off_q       <= '0;
                        pad_pending <= 1'b0;
                        msg_bytes   <= '0;
                    end
                end
                S_FILL: begin
                    if (xfer_in) begin
                        off_q     <= n_nxt;
                        msg_bytes <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
                        if (in_last && n_nxt != 5'd16) begin
                            blk_data <= buf_pad;
                            blk_last <= 1'b1;
                        end else begin
                            blk_data <= buf_wr;
                        end
                        if (in_last && n_nxt == 5'd16) pad_pending <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (xfer_out) begin
                        if (blk_last) begin
                            blk_last <= 1'b0;
                        end else if (pad_pending) begin
                            blk_data <= {16{8'h10}};
                            blk_last <= 1'b1;
                        end else begin
                            blk_data <= '0;
                            off_q    <= '0;
                        end
                    end
                end
                S_PADBLK: begin
                    if (xfer_out) begin
                        pad_pending <= 1'b0;
                        blk_last    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_block_packer_pkcs7.sv
// tb/tb_aes_block_packer_pkcs7.sv - randomized bench for aes_block_packer_pkcs7 against a byte-queue model
module tb_aes_block_packer_pkcs7;
    localparam int WORD_W = 32;
    localparam int WB     = WORD_W/8;
    localparam int NB_W   = $clog2(WB)+1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              msg_start;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic [NB_W-1:0]   in_nbytes;
    logic              in_ready;
    logic              cbc_start;
    logic [127:0]      blk_data;
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ready;
    logic              busy;
    logic [31:0]       msg_bytes;

    int checks = 0;
    int errors = 0;

    byte unsigned msg_q[$];
    logic [127:0] exp_blk[$];
    bit           exp_last[$];

    always #5 clk = ~clk;

    aes_block_packer_pkcs7 #(.WORD_W(WORD_W)) dut (
        .clk(clk), .reset_n(reset_n), .msg_start(msg_start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_nbytes(in_nbytes),
        .in_ready(in_ready), .cbc_start(cbc_start),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .busy(busy), .msg_bytes(msg_bytes)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: payload + PKCS#7 pad bytes, cut into 16-byte big-endian blocks.
    task automatic build_expect();
        byte unsigned p[$];
        int padn;
        logic [127:0] v;
        p = msg_q;
        padn = 16 - (msg_q.size() % 16);
        repeat (padn) p.push_back(8'(padn));
        exp_blk.delete();
        exp_last.delete();
        for (int b = 0; b < p.size()/16; b++) begin
            v = '0;
            for (int k = 0; k < 16; k++) v = {v[119:0], p[b*16+k]};
            exp_blk.push_back(v);
            exp_last.push_back(b == p.size()/16 - 1);
        end
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        repeat (len) msg_q.push_back(8'($urandom));
    endtask

    task automatic run_msg(input int stall, input int rdy_pct, input int vld_pct,
                           input bit bad_nb, input bit ign_start);
        int pos = 0;
        int bi = 0;
        int cyc = 0;
        int stall_cnt = 0;
        int len;
        int rem;
        logic [WORD_W-1:0] w;
        len = msg_q.size();
        build_expect();
        @(negedge clk);
        msg_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        msg_start = 1'b0;
        chk("cbc_start", cbc_start, 1);
        chk("busy_start", busy, 1);
        @(posedge clk);
        @(negedge clk);
        while (bi < exp_blk.size() && cyc < 2000) begin
            chk("cbc_once", cbc_start, 0);
            if (blk_valid) begin
                chk("in_ready_while_blk", in_ready, 0);
                chk("blk_data", blk_data, exp_blk[bi]);
                chk("blk_last", blk_last, exp_last[bi]);
            end
            if (blk_valid && stall_cnt < stall) begin
                blk_ready = 1'b0;
                stall_cnt++;
            end else begin
                blk_ready = ($urandom_range(99) < rdy_pct);
            end
            if (blk_valid && blk_ready) begin
                bi++;
                stall_cnt = 0;
            end
            in_valid = (pos < len) && ($urandom_range(99) < vld_pct);
            w = '0;
            for (int k = 0; k < WB; k++)
                w = {w[WORD_W-9:0], (pos+k < len) ? msg_q[pos+k] : 8'($urandom)};
            in_data = w;
            rem = len - pos;
            in_last = (rem <= WB);
            in_nbytes = in_last ? NB_W'(rem) : NB_W'($urandom);
            if (bad_nb && rem == WB) in_nbytes = '0;
            if (in_valid && in_ready) pos += WB;
            msg_start = ign_start && ($urandom_range(3) == 0);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        msg_start = 1'b0;
        blk_ready = 1'b1;
        chk("timeout", (cyc < 2000), 1);
        chk("busy_end", busy, 0);
        chk("blk_valid_end", blk_valid, 0);
        chk("msg_bytes", msg_bytes, 128'(len));
    endtask

    initial begin
        reset_n   = 1'b0;
        msg_start = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = '0;
        blk_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_msg_bytes", msg_bytes, 0);
        reset_n = 1'b1;
        @(negedge clk);

        msg_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                  8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_msg(0, 100, 100, 0, 0);

        msg_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        run_msg(0, 100, 100, 0, 0);

        rand_msg(20);
        run_msg(3, 100, 100, 0, 0);

        rand_msg(37);
        run_msg(0, 70, 80, 0, 1);

        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_last  = 1'b1;
        in_nbytes = 3'd4;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_msg_bytes", msg_bytes, 37);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        msg_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_msg(0, 100, 100, 1, 0);

        @(negedge clk);
        msg_start = 1'b1;
        @(negedge clk);
        msg_start = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        in_data   = 32'h01020304;
        repeat (3) @(posedge clk);
        #2;
        reset_n   = 1'b0;
        msg_start = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_blk_valid", blk_valid, 0);
        chk("arst_blk_data", blk_data, 0);
        chk("arst_blk_last", blk_last, 0);
        chk("arst_cbc_start", cbc_start, 0);
        chk("arst_msg_bytes", msg_bytes, 0);
        @(negedge clk);
        msg_start = 1'b0;
        in_valid  = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        rand_msg(9);
        run_msg(0, 100, 100, 0, 0);

        for (int t = 0; t < 30; t++) begin
            rand_msg($urandom_range(40, 1));
            run_msg($urandom_range(2), $urandom_range(100, 30), $urandom_range(100, 30),
                    $urandom_range(1), $urandom_range(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
